slave_in_port: RTL and testbench

- Serial-bus slave receive stage.
- Sits directly downstream of master_out_port, across the bus mux.
- Deserialises the address, burst length and write-data serial lines for one selected slave.
- Drives single-cycle write strobes to the slave memory core.
- Hands read requests (address plus length) to the slave's read-return port.

---
 rtl/serial_bus_pkg.sv | 26 ++
 rtl/serial_shift_rx.sv | 49 ++++
 rtl/slave_in_port.sv | 168 ++++++++++++++++
 tb/tb_slave_in_port.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bus_pkg.sv
// serial_bus_pkg: definitions shared by the serial-bus master and slave ports.
// Holds the default field widths, the bus instruction codes and the state
// encoding of the slave receive stage.
package serial_bus_pkg;

    localparam int ADDR_W  = 12;   // address bits, LSB-first
    localparam int WORD_W  = 8;    // data word bits, LSB-first
    localparam int BURST_W = 15;   // burst-length bits, LSB-first

    typedef enum logic [2:0] {
        S_READ    = 3'd1,
        S_WRITE   = 3'd2,
        S_B_READ  = 3'd3,
        S_B_WRITE = 3'd4
    } instr_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_RX,
        ST_DISPATCH,
        ST_BURST_RX,
        ST_DATA_RX,
        ST_READ_WAIT
    } rx_state_e;

endpackage

// File: rtl/serial_shift_rx.sv
// serial_shift_rx: LSB-first serial-to-parallel receiver with a bit counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of bits and counter (wins over en)
//   en         : sample bit_in this cycle
//   bit_in     : serial input bit
//   word       : bits received so far with the bit being sampled merged in,
//                so it is the complete word in the cycle done is high
//   done       : en is sampling the W-th bit of the current word
module serial_shift_rx #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         bit_in,
    output logic [W-1:0] word,
    output logic         done
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  bits;
    logic [CW-1:0] cnt;

    // NOTE: word gets its full default before the single-bit override, so no latch is inferred.
    always_comb begin
        word      = bits;
        word[cnt] = bit_in;
    end

    assign done = en && (cnt == CW'(W - 1));

    // NOTE: registered state is only ever updated with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits <= '0;
            cnt  <= '0;
        end else if (clr) begin
            bits <= '0;
            cnt  <= '0;
        end else if (en) begin
            bits <= word;
            cnt  <= done ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/slave_in_port.sv
// slave_in_port: serial-bus slave receive stage.
// Deserialises address, burst length and write data for one selected slave,
// issues one-cycle write strobes to the memory core and hands read requests
// to the read-return port.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   sel               : slave select for this slave
//   addr_bus          : serial address bit
//   burst_size_bus    : serial burst-length bit
//   w_data_bus        : serial write-data bit, qualified by m_valid
//   m_b_tx_valid      : master is sending a burst length (burst read)
//   read_en           : master requests a read
//   tx_done           : master finished the write transfer
//   split_on          : master aborted the transaction
//   rd_done           : read-return port finished sending data
//   s_ready           : slave can accept serial bits (low while a read is pending)
//   mem_we, mem_addr, mem_wdata : one-cycle write strobe, address and data
//   rd_req, rd_addr, rd_len     : one-cycle read request, start address, word count
//   busy              : transaction in progress
module slave_in_port #(
    parameter int ADDR_W  = serial_bus_pkg::ADDR_W,
    parameter int WORD_W  = serial_bus_pkg::WORD_W,
    parameter int BURST_W = serial_bus_pkg::BURST_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sel,
    input  logic               addr_bus,
    input  logic               burst_size_bus,
    input  logic               w_data_bus,
    input  logic               m_valid,
    input  logic               m_b_tx_valid,
    input  logic               read_en,
    input  logic               tx_done,
    input  logic               split_on,
    input  logic               rd_done,
    output logic               s_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WORD_W-1:0]  mem_wdata,
    output logic               rd_req,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic [BURST_W-1:0] rd_len,
    output logic               busy
);

    import serial_bus_pkg::*;

    rx_state_e state, state_next;

    logic               abort;
    logic               addr_done, len_done, data_done;
    logic               single_rd;
    logic [ADDR_W-1:0]  addr_word, cur_addr;
    logic [BURST_W-1:0] len_word;
    logic [WORD_W-1:0]  data_word;

    // Losing the select or a split kills any transaction in flight; the
    // shifters are gated with it so a word completing in the same cycle is
    // discarded along with the rest.
    assign abort = (state != ST_IDLE) && (split_on || !sel);

    // Each shifter is held clear outside its own state, so its bit count
    // always starts at zero and partial words are dropped on exit.
    serial_shift_rx #(.W(ADDR_W)) u_addr_rx (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state != ST_ADDR_RX),
        .en     ((state == ST_ADDR_RX) && !abort),
        .bit_in (addr_bus),
        .word   (addr_word),
        .done   (addr_done)
    );

    serial_shift_rx #(.W(BURST_W)) u_len_rx (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state != ST_BURST_RX),
        .en     ((state == ST_BURST_RX) && !abort),
        .bit_in (burst_size_bus),
        .word   (len_word),
        .done   (len_done)
    );

    serial_shift_rx #(.W(WORD_W)) u_data_rx (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state != ST_DATA_RX),
        .en     ((state == ST_DATA_RX) && m_valid && !abort),
        .bit_in (w_data_bus),
        .word   (data_word),
        .done   (data_done)
    );

    assign single_rd = (state == ST_DISPATCH) && !abort && read_en && !m_b_tx_valid;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:      if (sel) state_next = ST_ADDR_RX;
                ST_ADDR_RX:   if (addr_done) state_next = ST_DISPATCH;
                ST_DISPATCH: begin
                    if (read_en && !m_b_tx_valid) state_next = ST_READ_WAIT;
                    else if (m_b_tx_valid)        state_next = ST_BURST_RX;
                    else                          state_next = ST_DATA_RX;
                end
                ST_BURST_RX:  if (len_done) state_next = ST_READ_WAIT;
                // A word finishing together with tx_done is still strobed,
                // since the write path below keys off data_done alone.
                ST_DATA_RX:   if (tx_done) state_next = ST_IDLE;
                ST_READ_WAIT: if (rd_done) state_next = ST_IDLE;
                default:      state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Current address: loaded when the address completes, then advanced
    // (wrapping naturally at ADDR_W bits) after every written word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr <= '0;
        end else if (addr_done) begin
            cur_addr <= addr_word;
        end else if (data_done) begin
            cur_addr <= cur_addr + 1'b1;
        end
    end

    // Registered outputs: strobes last one cycle, their payloads hold until
    // the next strobe. s_ready follows the next state so it is low for
    // exactly the READ_WAIT cycles and rises on the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            rd_len    <= '0;
        end else begin
            s_ready <= (state_next != ST_READ_WAIT);
            mem_we  <= data_done;
            rd_req  <= single_rd || len_done;
            if (data_done) begin
                mem_addr  <= cur_addr;
                mem_wdata <= data_word;
            end
            if (single_rd) begin
                rd_addr <= cur_addr;
                rd_len  <= BURST_W'(1);
            end else if (len_done) begin
                rd_addr <= cur_addr;
                rd_len  <= (len_word == '0) ? BURST_W'(1) : len_word;
            end
        end
    end

endmodule

// File: tb/tb_slave_in_port.sv
// tb_slave_in_port: self-checking bench for slave_in_port. Transactions are
// driven at the falling edge; a monitor records every write strobe and read
// request at the falling edge, and each test compares those records with
// the transfers expected from the bus rules (address + word index, length 0
// read as 1).
module tb_slave_in_port;

    localparam int ADDR_W  = 12;
    localparam int WORD_W  = 8;
    localparam int BURST_W = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sel = 1'b0, addr_bus = 1'b0, burst_size_bus = 1'b0, w_data_bus = 1'b0;
    logic m_valid = 1'b0, m_b_tx_valid = 1'b0, read_en = 1'b0, tx_done = 1'b0;
    logic split_on = 1'b0, rd_done = 1'b0;
    logic               s_ready, mem_we, rd_req, busy;
    logic [ADDR_W-1:0]  mem_addr, rd_addr;
    logic [WORD_W-1:0]  mem_wdata;
    logic [BURST_W-1:0] rd_len;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0]  exp_waddr[$], obs_waddr[$], exp_raddr[$], obs_raddr[$];
    logic [WORD_W-1:0]  exp_wdata[$], obs_wdata[$];
    logic [BURST_W-1:0] exp_rlen[$],  obs_rlen[$];
    logic [WORD_W-1:0]  wq[$];

    always #5 clk = ~clk;

    slave_in_port dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sel            (sel),
        .addr_bus       (addr_bus),
        .burst_size_bus (burst_size_bus),
        .w_data_bus     (w_data_bus),
        .m_valid        (m_valid),
        .m_b_tx_valid   (m_b_tx_valid),
        .read_en        (read_en),
        .tx_done        (tx_done),
        .split_on       (split_on),
        .rd_done        (rd_done),
        .s_ready        (s_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_len         (rd_len),
        .busy           (busy)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                obs_waddr.push_back(mem_addr);
                obs_wdata.push_back(mem_wdata);
            end
            if (rd_req) begin
                obs_raddr.push_back(rd_addr);
                obs_rlen.push_back(rd_len);
            end
        end
    end

    task automatic clear_q();
        exp_waddr.delete(); exp_wdata.delete(); exp_raddr.delete(); exp_rlen.delete();
        obs_waddr.delete(); obs_wdata.delete(); obs_raddr.delete(); obs_rlen.delete();
    endtask

    // Select the slave and shift the address; returns at the DISPATCH cycle.
    task automatic send_header(input logic [ADDR_W-1:0] a);
        sel = 1'b1;
        @(negedge clk);
        for (int i = 0; i < ADDR_W; i++) begin
            addr_bus = a[i];
            @(negedge clk);
        end
        addr_bus = 1'b0;
    endtask

    // Write the words in wq starting at a; records the expected strobes.
    task automatic do_write(input logic [ADDR_W-1:0] a, input bit gaps, input bit coincide);
        send_header(a);
        @(negedge clk);
        foreach (wq[k]) begin
            exp_waddr.push_back(ADDR_W'((int'(a) + k) % (1 << ADDR_W)));
            exp_wdata.push_back(wq[k]);
            for (int b = 0; b < WORD_W; b++) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    m_valid    = 1'b0;
                    w_data_bus = 1'($urandom);
                    @(negedge clk);
                end
                m_valid    = 1'b1;
                w_data_bus = wq[k][b];
                if (coincide && k == wq.size() - 1 && b == WORD_W - 1) tx_done = 1'b1;
                @(negedge clk);
            end
        end
        m_valid = 1'b0;
        if (!coincide) begin
            tx_done = 1'b1;
            @(negedge clk);
        end
        tx_done = 1'b0;
        sel     = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Single or burst read; low_ok reports s_ready low and busy high while waiting.
    task automatic do_read(input logic [ADDR_W-1:0] a, input bit burst,
                           input logic [BURST_W-1:0] len, input int wait_cyc,
                           output bit low_ok);
        send_header(a);
        read_en = 1'b1;
        if (burst) begin
            m_b_tx_valid = 1'b1;
            @(negedge clk);
            for (int i = 0; i < BURST_W; i++) begin
                burst_size_bus = len[i];
                @(negedge clk);
            end
            exp_rlen.push_back((len == '0) ? BURST_W'(1) : len);
        end else begin
            @(negedge clk);
            exp_rlen.push_back(BURST_W'(1));
        end
        exp_raddr.push_back(a);
        read_en = 1'b0; m_b_tx_valid = 1'b0; burst_size_bus = 1'b0;
        low_ok = 1'b1;
        for (int i = 0; i <= wait_cyc; i++) begin
            if (s_ready !== 1'b0 || busy !== 1'b1) low_ok = 1'b0;
            if (i < wait_cyc) @(negedge clk);
        end
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        sel     = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({s_ready, mem_we, rd_req, busy} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl got s_ready/mem_we/rd_req/busy=%b exp=0000", {s_ready, mem_we, rd_req, busy});
        end
        total++;
        if (mem_addr !== '0 || mem_wdata !== '0 || rd_addr !== '0 || rd_len !== '0) begin
            bad++;
            $display("FAIL reset_data got %h %h %h %h exp all zero", mem_addr, mem_wdata, rd_addr, rd_len);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got s_ready=%b busy=%b exp s_ready=1 busy=0", s_ready, busy);
        end
    endtask

    task automatic test_write();
        logic [ADDR_W-1:0] starts[4] = '{12'h5A3, 12'h0FE, 12'hFFF, 12'h7C0};
        for (int c = 0; c < 4; c++) begin
            clear_q();
            wq.delete();
            case (c)
                0: wq.push_back(8'hC6);
                1: begin wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33); end
                2: begin wq.push_back(8'($urandom)); wq.push_back(8'($urandom)); end
                default: begin wq.push_back(8'($urandom)); wq.push_back(8'($urandom)); end
            endcase
            do_write(starts[c], c == 3, c == 3);
            total++;
            if (obs_waddr.size() != exp_waddr.size()) begin
                bad++;
                $display("FAIL write_count case %0d got=%0d exp=%0d", c, obs_waddr.size(), exp_waddr.size());
            end else begin
                foreach (exp_waddr[i]) begin
                    total++;
                    if (obs_waddr[i] !== exp_waddr[i] || obs_wdata[i] !== exp_wdata[i]) begin
                        bad++;
                        $display("FAIL write case %0d word %0d got=%h:%h exp=%h:%h", c, i,
                                 obs_waddr[i], obs_wdata[i], exp_waddr[i], exp_wdata[i]);
                    end
                end
            end
            total++;
            if (busy !== 1'b0 || s_ready !== 1'b1 || obs_raddr.size() != 0) begin
                bad++;
                $display("FAIL write_idle case %0d got busy=%b s_ready=%b rd_reqs=%0d exp 0 1 0", c, busy, s_ready, obs_raddr.size());
            end
        end
    endtask

    task automatic test_read();
        logic [ADDR_W-1:0]  addrs[4] = '{12'h123, 12'h040, 12'h040, 12'hABC};
        logic [BURST_W-1:0] lens[4]  = '{15'd0, 15'd7, 15'd0, 15'h7FFF};
        bit                 low_ok;
        for (int c = 0; c < 4; c++) begin
            clear_q();
            do_read(addrs[c], c != 0, lens[c], 1 + c, low_ok);
            total++;
            if (!low_ok) begin
                bad++;
                $display("FAIL read_wait case %0d got s_ready high or busy low while waiting exp s_ready=0 busy=1", c);
            end
            total++;
            if (obs_raddr.size() != 1 || obs_waddr.size() != 0) begin
                bad++;
                $display("FAIL read_count case %0d got rd_req=%0d mem_we=%0d exp 1 0", c, obs_raddr.size(), obs_waddr.size());
            end else begin
                total++;
                if (obs_raddr[0] !== exp_raddr[0] || obs_rlen[0] !== exp_rlen[0]) begin
                    bad++;
                    $display("FAIL read case %0d got addr=%h len=%0d exp addr=%h len=%0d", c,
                             obs_raddr[0], obs_rlen[0], exp_raddr[0], exp_rlen[0]);
                end
            end
            total++;
            if (s_ready !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL read_idle case %0d got s_ready=%b busy=%b exp 1 0", c, s_ready, busy);
            end
        end
    endtask

    task automatic test_abort();
        clear_q();
        send_header(12'h2A5);
        @(negedge clk);
        for (int b = 0; b < 5; b++) begin
            m_valid = 1'b1; w_data_bus = 1'($urandom);
            @(negedge clk);
        end
        m_valid = 1'b0; split_on = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL split_idle got busy=%b exp 0", busy);
        end
        split_on = 1'b0; sel = 1'b0;
        for (int b = 0; b < 3; b++) begin
            m_valid = 1'b1; w_data_bus = 1'($urandom);
            @(negedge clk);
        end
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (obs_waddr.size() != 0) begin
            bad++;
            $display("FAIL split_no_write got mem_we=%0d exp 0", obs_waddr.size());
        end

        clear_q();
        sel = 1'b1;
        @(negedge clk);
        for (int i = 0; i < ADDR_W; i++) begin
            if (i == 6) sel = 1'b0;
            addr_bus = 1'($urandom);
            @(negedge clk);
            if (i == 6) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL sel_drop_idle got busy=%b exp 0", busy);
                end
            end
        end
        read_en = 1'b1;
        @(negedge clk);
        read_en = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (obs_raddr.size() != 0 || obs_waddr.size() != 0) begin
            bad++;
            $display("FAIL sel_drop_quiet got rd_req=%0d mem_we=%0d exp 0 0", obs_raddr.size(), obs_waddr.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [WORD_W-1:0] w0;
        w0 = 8'($urandom);
        clear_q();
        send_header(12'h3C9);
        @(negedge clk);
        for (int b = 0; b < WORD_W + 3; b++) begin
            m_valid = 1'b1;
            w_data_bus = (b < WORD_W) ? w0[b] : 1'($urandom);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({s_ready, mem_we, rd_req, busy} !== 4'b0000 || mem_addr !== '0 || mem_wdata !== '0
            || rd_addr !== '0 || rd_len !== '0) begin
            bad++;
            $display("FAIL reset_mid got ctrl=%b mem=%h:%h rd=%h:%0d exp all zero",
                     {s_ready, mem_we, rd_req, busy}, mem_addr, mem_wdata, rd_addr, rd_len);
        end
        @(negedge clk);
        rst_n = 1'b1; sel = 1'b0; m_valid = 1'b0;
        @(negedge clk);
        total++;
        if (obs_waddr.size() != 1 || obs_waddr[0] !== 12'h3C9 || obs_wdata[0] !== w0) begin
            bad++;
            $display("FAIL reset_mid_writes got count=%0d exp one write %h:%h", obs_waddr.size(), 12'h3C9, w0);
        end
        clear_q();
        wq.delete();
        wq.push_back(8'($urandom));
        wq.push_back(8'($urandom));
        do_write(12'h3C9, 1'b0, 1'b0);
        total++;
        if (obs_waddr.size() != 2 || obs_waddr[0] !== exp_waddr[0] || obs_wdata[0] !== exp_wdata[0]
            || obs_waddr[1] !== exp_waddr[1] || obs_wdata[1] !== exp_wdata[1]) begin
            bad++;
            $display("FAIL reset_recover got count=%0d exp 2 writes at %h/%h", obs_waddr.size(), exp_waddr[0], exp_waddr[1]);
        end
    endtask

    task automatic test_back_to_back();
        bit low_ok;
        for (int t = 0; t < 12; t++) begin
            clear_q();
            low_ok = 1'b1;
            if ($urandom_range(0, 1) == 0) begin
                wq.delete();
                for (int n = $urandom_range(1, 4); n > 0; n--) wq.push_back(8'($urandom));
                do_write(ADDR_W'($urandom), 1'b1, 1'($urandom));
            end else begin
                do_read(ADDR_W'($urandom), 1'($urandom),
                        ($urandom_range(0, 3) == 0) ? '0 : BURST_W'($urandom_range(1, 32767)),
                        $urandom_range(0, 4), low_ok);
            end
            total++;
            if (!low_ok || obs_waddr.size() != exp_waddr.size() || obs_raddr.size() != exp_raddr.size()) begin
                bad++;
                $display("FAIL b2b_count txn %0d got writes=%0d reads=%0d wait_ok=%b exp writes=%0d reads=%0d wait_ok=1",
                         t, obs_waddr.size(), obs_raddr.size(), low_ok, exp_waddr.size(), exp_raddr.size());
            end else begin
                foreach (exp_waddr[i]) begin
                    total++;
                    if (obs_waddr[i] !== exp_waddr[i] || obs_wdata[i] !== exp_wdata[i]) begin
                        bad++;
                        $display("FAIL b2b_write txn %0d word %0d got=%h:%h exp=%h:%h", t, i,
                                 obs_waddr[i], obs_wdata[i], exp_waddr[i], exp_wdata[i]);
                    end
                end
                foreach (exp_raddr[i]) begin
                    total++;
                    if (obs_raddr[i] !== exp_raddr[i] || obs_rlen[i] !== exp_rlen[i]) begin
                        bad++;
                        $display("FAIL b2b_read txn %0d got addr=%h len=%0d exp addr=%h len=%0d", t,
                                 obs_raddr[i], obs_rlen[i], exp_raddr[i], exp_rlen[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
